mem_fifo_ctrl: RTL

Flow-control front end for a two-port memory wrapper built as a FIFO (e.g. `rx_fifo_mem_wrapper`, `wt_fifo_mem_wrapper`). Accepts a valid/ready push stream and generates `wr`/`waddr`/`wdata`. Issues prefetch reads (`rd`/`raddr`) and absorbs the wrapper's fixed read latency in a small output buffer. Presents a valid/ready pop stream. Sits directly upstream of the memory wrapper and consumes its `rdata`.

---
 rtl/mem_fifo_ctrl_pkg.sv | 15 +
 rtl/mem_fifo_ctrl_obuf.sv | 56 +++++
 rtl/mem_fifo_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_fifo_ctrl_pkg.sv
// Shared constants and helpers for the mem_fifo_ctrl flow-control front end.
package mem_fifo_ctrl_pkg;

    localparam int RD_LAT_DEFAULT = 3;

    // Two slots beyond the read latency let a credit return and be reused without a bubble.
    function automatic int obuf_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/mem_fifo_ctrl_obuf.sv
// Small flop FIFO that absorbs read data returning from the memory wrapper.
module mem_fifo_ctrl_obuf
    import mem_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH      = 6,
    parameter int OBUF_DEPTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int CW = $clog2(OBUF_DEPTH + 1);

    logic [WIDTH-1:0] store [OBUF_DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    always_ff @(posedge clk) begin
        if (push) begin
            store[tail] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= PW'(ptr_inc(32'(tail), OBUF_DEPTH));
            end
            if (pop) begin
                head <= PW'(ptr_inc(32'(head), OBUF_DEPTH));
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    assign empty = (count == '0);

    // An empty buffer presents zero so stale slots never leak onto the output.
    assign pop_data = empty ? '0 : store[head];

endmodule

// File: rtl/mem_fifo_ctrl.sv
// FIFO flow-control front end for a fixed-latency two-port memory wrapper.
// Optional MEM_FIFO_CTRL_LEVEL_EN adds fill_level/afull reporting.
module mem_fifo_ctrl
    import mem_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH      = 6,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int RD_LAT     = RD_LAT_DEFAULT,
    localparam int OBUF_DEPTH = obuf_depth(RD_LAT)
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef MEM_FIFO_CTRL_LEVEL_EN
    input  logic [$clog2(DEPTH + OBUF_DEPTH + 1)-1:0] afull_thresh,
    output logic [$clog2(DEPTH + OBUF_DEPTH + 1)-1:0] fill_level,
    output logic                  afull,
`endif
    input  logic                  push_vld,
    output logic                  push_rdy,
    input  logic [WIDTH-1:0]      push_data,
    output logic                  pop_vld,
    input  logic                  pop_rdy,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  wr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [WIDTH-1:0]      wdata,
    output logic                  rd,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [WIDTH-1:0]      rdata,
    output logic                  empty,
    output logic                  full
);

    localparam int MC_W = $clog2(DEPTH + 1);
    localparam int CW   = $clog2(OBUF_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [MC_W-1:0]       mem_cnt;
    logic [CW-1:0]         credit;
    logic [RD_LAT-1:0]     inflight;
    logic                  obuf_empty;
    logic                  pop_hs;

    assign push_rdy = (mem_cnt != MC_W'(DEPTH));
    assign full     = !push_rdy;
    assign wr       = push_vld && push_rdy;
    assign waddr    = wptr;
    assign wdata    = push_data;

    // Reads are issued only from registered state so rd never depends on this cycle's push.
    assign rd     = (mem_cnt != '0) && (credit != '0);
    assign raddr  = rptr;
    assign pop_vld = !obuf_empty;
    assign pop_hs  = pop_vld && pop_rdy;
    assign empty   = (mem_cnt == '0) && (inflight == '0) && obuf_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            credit   <= CW'(OBUF_DEPTH);
            inflight <= '0;
        end else begin
            if (wr) begin
                wptr <= ADDR_WIDTH'(ptr_inc(32'(wptr), DEPTH));
            end
            if (rd) begin
                rptr <= ADDR_WIDTH'(ptr_inc(32'(rptr), DEPTH));
            end
            case ({wr, rd})
                2'b10:   mem_cnt <= mem_cnt + MC_W'(1);
                2'b01:   mem_cnt <= mem_cnt - MC_W'(1);
                default: ;
            endcase
            case ({rd, pop_hs})
                2'b10:   credit <= credit - CW'(1);
                2'b01:   credit <= credit + CW'(1);
                default: ;
            endcase
            inflight[0] <= rd;
            for (int i = 1; i < RD_LAT; i++) begin
                inflight[i] <= inflight[i-1];
            end
        end
    end

    // Credits bound the buffer occupancy; leaving 0..OBUF_DEPTH means the accounting broke.
    assert property (@(posedge clk) disable iff (rst)
        !((rd && !pop_hs && credit == '0) ||
          (pop_hs && !rd && credit == CW'(OBUF_DEPTH))));

    mem_fifo_ctrl_obuf #(
        .WIDTH      (WIDTH),
        .OBUF_DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight[RD_LAT-1]),
        .push_data (rdata),
        .pop       (pop_hs),
        .pop_data  (pop_data),
        .empty     (obuf_empty)
    );

`ifdef MEM_FIFO_CTRL_LEVEL_EN
    localparam int LEVEL_W = $clog2(DEPTH + OBUF_DEPTH + 1);

    logic [LEVEL_W-1:0] level_next;

    // Entries only enter on a push and leave on a pop, so the total is a simple up/down count.
    always_comb begin
        level_next = fill_level;
        if (wr && !pop_hs) begin
            level_next = fill_level + LEVEL_W'(1);
        end else if (!wr && pop_hs) begin
            level_next = fill_level - LEVEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_level <= '0;
            afull      <= 1'b0;
        end else begin
            fill_level <= level_next;
            afull      <= (level_next >= afull_thresh);
        end
    end
`endif

endmodule
